// File: rtl/exe_muldiv_ctrl_pkg.sv
// Shared constants and types for the EXE-stage multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned ITER = 32;

  typedef logic [1:0] muldiv_op_t;

  localparam muldiv_op_t OP_MULT  = 2'b00;
  localparam muldiv_op_t OP_MULTU = 2'b01;
  localparam muldiv_op_t OP_DIV   = 2'b10;
  localparam muldiv_op_t OP_DIVU  = 2'b11;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } muldiv_state_e;

endpackage

// File: rtl/exe_muldiv_ctrl_if.sv
// EXE-stage <-> multiply/divide sequencer bundle: issue, HI/LO writes, stall and results.
interface exe_muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic        exe_flush;
  logic        start;
  muldiv_op_t  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output exe_flush, start, op, src_a, src_b, mthi, mtlo, wdata,
    input  stall, busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  exe_flush, start, op, src_a, src_b, mthi, mtlo, wdata,
    output stall, busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/exe_muldiv_ctrl_step.sv
// One iteration of the magnitude loop: right shift-add for multiply, restoring
// shift-subtract for divide, both on the {acc, opnd} register pair.
module muldiv_step (
  input  logic        is_div,
  input  logic [31:0] acc,
  input  logic [31:0] opnd,
  input  logic [31:0] mcand,
  output logic [31:0] acc_nxt,
  output logic [31:0] opnd_nxt
);

  logic [32:0] sum;
  logic [32:0] part_rem;
  logic        fits;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, (opnd[0] ? mcand : 32'd0)};
    part_rem = {acc, opnd[31]};
    fits     = (part_rem >= {1'b0, mcand});
    if (is_div) begin
      // Remainder after a successful subtract is below the divisor, so 32 bits hold it.
      acc_nxt  = fits ? (part_rem[31:0] - mcand) : part_rem[31:0];
      opnd_nxt = {opnd[30:0], fits};
    end else begin
      acc_nxt  = sum[32:1];
      opnd_nxt = {sum[0], opnd[31:1]};
    end
  end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer owning HI/LO; stalls the pipeline
// while busy and treats exe_flush as an abort.
module exe_muldiv_ctrl #(
  parameter int unsigned ITER = muldiv_pkg::ITER
) (
  input logic              clk,
  input logic              reset,
  exe_muldiv_ctrl_if.slave bus
);
  import muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(ITER);

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     acc_q, acc_d, opnd_q, opnd_d, mcand_q, mcand_d;
  logic            is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            done_q, done_d, dbz_q, dbz_d;

  logic [31:0] step_acc, step_opnd, mag_a, mag_b, quo, rem;
  logic [63:0] prod, prod_fix;
  logic        op_div, op_signed, div_zero, accept, last;

  assign op_div    = bus.op[1];
  assign op_signed = ~bus.op[0];
  assign div_zero  = op_div && (bus.src_b == 32'd0);
  assign mag_a     = (op_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign mag_b     = (op_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;
  assign accept    = (state_q == IDLE) && bus.start && !bus.exe_flush && !div_zero;
  assign last      = (count_q == CntW'(ITER - 1));

  muldiv_step u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .mcand    (mcand_q),
    .acc_nxt  (step_acc),
    .opnd_nxt (step_opnd)
  );

  // Sign correction is applied to the final iteration's output so HI/LO land on that edge.
  assign prod     = {step_acc, step_opnd};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo      = neg_res_q ? -step_opnd : step_opnd;
  assign rem      = neg_rem_q ? -step_acc : step_acc;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.exe_flush) begin
          state_d = IDLE;
        end else if (bus.start) begin
          if (div_zero) begin
            done_d = 1'b1;
            dbz_d  = 1'b1;
          end else begin
            state_d   = BUSY;
            count_d   = '0;
            acc_d     = '0;
            opnd_d    = mag_a;
            mcand_d   = mag_b;
            is_div_d  = op_div;
            neg_res_d = op_signed && (bus.src_a[31] ^ bus.src_b[31]);
            neg_rem_d = op_signed && bus.src_a[31];
          end
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      BUSY: begin
        if (bus.exe_flush) begin
          state_d = IDLE;
        end else begin
          acc_d   = step_acc;
          opnd_d  = step_opnd;
          count_d = count_q + 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (is_div_q) begin
              hi_d = rem;
              lo_d = quo;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.stall       = accept || (state_q == BUSY);
  assign bus.busy        = (state_q == BUSY);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// Randomised self-checking bench for exe_muldiv_ctrl against an arithmetic HI/LO model.
module tb_exe_muldiv_ctrl;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  exe_muldiv_ctrl_if bus ();

  exe_muldiv_ctrl #(.ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // {hi, lo} from plain arithmetic; divide-by-zero leaves the pair untouched.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = {exp_hi, exp_lo};
    case (op)
      OP_MULT:  r = sa * sb;
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: if (b != 0) begin
        q = sa / sb;
        m = sa % sb;
        r = {m[31:0], q[31:0]};
      end
      default: if (b != 0) r = {a % b, a / b};
    endcase
    return r;
  endfunction

  task automatic write_hilo(input bit h, input bit l, input logic [31:0] data);
    bus.mthi  = h;
    bus.mtlo  = l;
    bus.wdata = data;
    step();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    if (h) exp_hi = data;
    if (l) exp_lo = data;
    check_eq("mt_hi", bus.hi, exp_hi);
    check_eq("mt_lo", bus.lo, exp_lo);
  endtask

  // abort_at: BUSY cycle (>=5) to flush or reset in; 0 runs to completion.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input bit use_rst);
    logic [63:0] exp;
    bit dz;
    int stall_cnt, early_done;
    exp        = model(op, a, b);
    dz         = op[1] && (b == 32'd0);
    early_done = 0;
    bus.start  = 1'b1;
    bus.op     = op;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.mthi   = 1'($urandom_range(0, 1));
    bus.wdata  = $urandom();
    #1;
    stall_cnt = bus.stall ? 1 : 0;
    step();
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    if (dz) begin
      check_eq("dz_stall", 64'(stall_cnt), 64'd0);
      check_eq("dz_done", bus.done, 1'b1);
      check_eq("dz_flag", bus.div_by_zero, 1'b1);
      check_eq("dz_hi", bus.hi, exp_hi);
      check_eq("dz_lo", bus.lo, exp_lo);
      return;
    end
    check_eq("busy_c1", bus.busy, 1'b1);
    for (int c = 1; c <= int'(ITER); c++) begin
      if (c == 3) begin
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = $urandom();
      end
      if (c == 4) begin
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
      end
      if (c == abort_at && use_rst) begin
        reset = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_stall", bus.stall, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_hi", bus.hi, 64'd0);
        check_eq("rst_lo", bus.lo, 64'd0);
        step();
        reset = 1'b1;
        step();
        return;
      end
      if (c == abort_at) begin
        bus.exe_flush = 1'b1;
        step();
        bus.exe_flush = 1'b0;
        check_eq("fl_busy", bus.busy, 1'b0);
        check_eq("fl_done", bus.done, 1'b0);
        check_eq("fl_hi", bus.hi, exp_hi);
        check_eq("fl_lo", bus.lo, exp_lo);
        step();
        check_eq("fl_done2", bus.done, 1'b0);
        return;
      end
      #1;
      if (bus.stall) stall_cnt++;
      if (bus.done) early_done++;
      step();
    end
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
    check_eq("stall_cycles", 64'(stall_cnt), 64'd33);
    check_eq("early_done", 64'(early_done), 64'd0);
    check_eq("done", bus.done, 1'b1);
    check_eq("dbz_low", bus.div_by_zero, 1'b0);
    check_eq("busy_end", bus.busy, 1'b0);
    check_eq("hi", bus.hi, exp_hi);
    check_eq("lo", bus.lo, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bus.exe_flush = 1'b0;
    bus.start     = 1'b0;
    bus.op        = OP_MULT;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.mthi      = 1'b0;
    bus.mtlo      = 1'b0;
    bus.wdata     = '0;
    repeat (2) step();
    check_eq("r_busy", bus.busy, 1'b0);
    check_eq("r_done", bus.done, 1'b0);
    check_eq("r_dbz", bus.div_by_zero, 1'b0);
    check_eq("r_stall", bus.stall, 1'b0);
    check_eq("r_hi", bus.hi, 64'd0);
    check_eq("r_lo", bus.lo, 64'd0);
    reset = 1'b1;
    step();

    run_op(OP_MULT, -32'sd3, 32'd7, 0, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(OP_DIV, -32'sd7, 32'd2, 0, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    write_hilo(1'b1, 1'b0, 32'h1234);
    write_hilo(1'b0, 1'b1, 32'h5678);
    run_op(OP_DIVU, 32'd5, 32'd0, 0, 1'b0);
    step();
    run_op(OP_MULT, 32'd9, 32'd9, 10, 1'b0);
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    run_op(OP_MULTU, 32'd3, 32'd4, 0, 1'b0);

    // Flush in IDLE blocks both the issue and a concurrent HI write.
    bus.start     = 1'b1;
    bus.op        = OP_MULT;
    bus.exe_flush = 1'b1;
    bus.mthi      = 1'b1;
    bus.wdata     = $urandom();
    #1;
    check_eq("if_stall", bus.stall, 1'b0);
    step();
    bus.start     = 1'b0;
    bus.exe_flush = 1'b0;
    bus.mthi      = 1'b0;
    check_eq("if_busy", bus.busy, 1'b0);
    check_eq("if_hi", bus.hi, exp_hi);

    run_op(OP_MULT, 32'd11, 32'd13, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
      run_op(2'($urandom_range(0, 3)), pick(), pick(),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 32)) : 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
